// File: rtl/ws2812_tx.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_tx
// Brief    : WS2812 single-pixel serialiser; optional WS2812_TX_BRIGHTNESS_EN
//            adds a per-channel right-shift brightness input.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_tx #(
    parameter int CYCLES_PER_BIT = 15,
    parameter int T0H_CYCLES     = 4,
    parameter int T1H_CYCLES     = 9,
    parameter int BITS_PER_PIXEL = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_sreg,
    input  logic        transmit_pixel,
    input  logic [23:0] pixel_data,
`ifdef WS2812_TX_BRIGHTNESS_EN
    input  logic [2:0]  brightness,
`endif
    output logic        data_out,
    output logic        busy,
    output logic        pixel_done,
    output logic        underrun
);

    localparam logic [3:0] C_CYC_LAST = 4'(CYCLES_PER_BIT - 1);
    localparam logic [3:0] C_T0H      = 4'(T0H_CYCLES);
    localparam logic [3:0] C_T1H      = 4'(T1H_CYCLES);
    localparam logic [4:0] C_BIT_LAST = 5'(BITS_PER_PIXEL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_SEND   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] sreg, sreg_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [3:0]  cyc_cnt, cyc_cnt_nxt;
    logic        data_nxt, done_nxt, underrun_nxt;
    logic [23:0] load_word;
    logic [3:0]  high_len;

`ifdef WS2812_TX_BRIGHTNESS_EN
    assign load_word = {pixel_data[23:16] >> brightness,
                        pixel_data[15:8]  >> brightness,
                        pixel_data[7:0]   >> brightness};
`else
    assign load_word = pixel_data;
`endif

    assign high_len = sreg[23] ? C_T1H : C_T0H;

    always_comb begin
        state_nxt    = state;
        sreg_nxt     = sreg;
        bit_cnt_nxt  = bit_cnt;
        cyc_cnt_nxt  = cyc_cnt;
        data_nxt     = 1'b0;
        done_nxt     = 1'b0;
        underrun_nxt = underrun;

        if (load_sreg) begin
            sreg_nxt    = load_word;
            bit_cnt_nxt = 5'd0;
            cyc_cnt_nxt = 4'd0;
            state_nxt   = S_LOADED;
        end else begin
            case (state)
                S_IDLE: begin
                    if (transmit_pixel) underrun_nxt = 1'b1;
                end
                S_LOADED, S_SEND: begin
                    if (transmit_pixel) begin
                        data_nxt  = (cyc_cnt < high_len);
                        state_nxt = S_SEND;
                        if (cyc_cnt == C_CYC_LAST) begin
                            cyc_cnt_nxt = 4'd0;
                            sreg_nxt    = {sreg[22:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 5'd1;
                            if (bit_cnt == C_BIT_LAST) begin
                                state_nxt = S_IDLE;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            cyc_cnt_nxt = cyc_cnt + 4'd1;
                        end
                    end else if (state == S_SEND) begin
                        // Controller withdrew mid-frame: abandon without pixel_done.
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sreg       <= 24'd0;
            bit_cnt    <= 5'd0;
            cyc_cnt    <= 4'd0;
            data_out   <= 1'b0;
            pixel_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            cyc_cnt    <= cyc_cnt_nxt;
            data_out   <= data_nxt;
            pixel_done <= done_nxt;
            underrun   <= underrun_nxt;
        end
    end

    assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ws2812_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_tx
// Brief    : Directed self-checking bench for ws2812_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_sreg = 1'b0;
    logic        transmit_pixel = 1'b0;
    logic [23:0] pixel_data = 24'd0;
`ifdef WS2812_TX_BRIGHTNESS_EN
    logic [2:0]  brightness = 3'd0;
`endif
    logic        data_out, busy, pixel_done, underrun;

    int vectors = 0;
    int errors  = 0;

    ws2812_tx dut (
        .clk            (clk),
        .rst            (rst),
        .load_sreg      (load_sreg),
        .transmit_pixel (transmit_pixel),
        .pixel_data     (pixel_data),
`ifdef WS2812_TX_BRIGHTNESS_EN
        .brightness     (brightness),
`endif
        .data_out       (data_out),
        .busy           (busy),
        .pixel_done     (pixel_done),
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [23:0] w);
        load_sreg  = 1'b1;
        pixel_data = w;
        tick();
        load_sreg  = 1'b0;
    endtask

    // Drives transmit_pixel for ncyc cycles; expected waveform from the bit timing rule.
    task automatic run_frame(input logic [23:0] w, input int ncyc);
        logic [23:0] word;
        int k, ph;
        logic exp_d;
        word = w;
        transmit_pixel = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            k     = i / 15;
            ph    = i % 15;
            exp_d = (ph < (word[23-k] ? 9 : 4));
            check($sformatf("data_out[%0d]", i), {31'd0, data_out}, {31'd0, exp_d});
            check($sformatf("pixel_done[%0d]", i), {31'd0, pixel_done}, {31'd0, (i == 359)});
            check($sformatf("busy[%0d]", i), {31'd0, busy}, {31'd0, (i != 359)});
        end
        transmit_pixel = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_data_out", {31'd0, data_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pixel_done", {31'd0, pixel_done}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);

        // Single '1' MSB followed by 23 zeros
        load(24'h800000);
        check("loaded_busy", {31'd0, busy}, 32'd1);
        check("loaded_data_out", {31'd0, data_out}, 32'd0);
        run_frame(24'h800000, 360);
        tick();
        check("post_frame_done", {31'd0, pixel_done}, 32'd0);
        check("post_frame_underrun", {31'd0, underrun}, 32'd0);

        // LOADED holds while transmit_pixel is low
        load(24'hFFFFFF);
        tick();
        tick();
        check("hold_busy", {31'd0, busy}, 32'd1);
        check("hold_data_out", {31'd0, data_out}, 32'd0);
        run_frame(24'hFFFFFF, 360);
        load(24'h000000);
        check("b2b_done_cleared", {31'd0, pixel_done}, 32'd0);
        run_frame(24'h000000, 360);

        // Abort at cycle 100
        load(24'hA5A5A5);
        run_frame(24'hA5A5A5, 100);
        tick();
        check("abort_data_out", {31'd0, data_out}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, pixel_done}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("abort_no_done", {31'd0, pixel_done}, 32'd0);
        end

        // Underrun after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        transmit_pixel = 1'b1;
        tick();
        tick();
        check("underrun_set", {31'd0, underrun}, 32'd1);
        check("underrun_data_out", {31'd0, data_out}, 32'd0);
        check("underrun_busy", {31'd0, busy}, 32'd0);
        transmit_pixel = 1'b0;
        tick();
        check("underrun_sticky", {31'd0, underrun}, 32'd1);
        load(24'h123456);
        check("underrun_sticky_load", {31'd0, underrun}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("underrun_cleared", {31'd0, underrun}, 32'd0);

        // Reset at bit 10 overrides an accompanying load
        load(24'hFFFFFF);
        run_frame(24'hFFFFFF, 155);
        rst       = 1'b1;
        load_sreg = 1'b1;
        transmit_pixel = 1'b1;
        tick();
        rst       = 1'b0;
        load_sreg = 1'b0;
        transmit_pixel = 1'b0;
        check("midrst_data_out", {31'd0, data_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, pixel_done}, 32'd0);
        check("midrst_underrun", {31'd0, underrun}, 32'd0);
        load(24'h5AC30F);
        run_frame(24'h5AC30F, 360);

`ifdef WS2812_TX_BRIGHTNESS_EN
        brightness = 3'd1;
        load(24'hFF8001);
        brightness = 3'd0;
        run_frame(24'h7F4000, 360);
`endif

        tick();
        check("final_idle_busy", {31'd0, busy}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_BIT, default 15, clock cycles per serial bit.
REQ-002 The block SHALL have parameter T0H_CYCLES, default 4, high-time cycles for a '0' bit.
REQ-003 The block SHALL have parameter T1H_CYCLES, default 9, high-time cycles for a '1' bit.
REQ-004 The block SHALL have parameter BITS_PER_PIXEL, default 24, serial bits per pixel word.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  system clock, sole clock, rising-edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 load_sreg  input  1  one-cycle strobe; capture pixel_data into the shift register.
REQ-008 transmit_pixel  input  1  level; high for the whole serial frame of the loaded pixel.
REQ-009 pixel_data  input  24  pixel word, GRB order, G[7] at bit 23.
REQ-010 data_out  output  1  registered serial line to the LED chain.
REQ-011 busy  output  1  high in LOADED or SEND.
REQ-012 pixel_done  output  1  one-cycle pulse after the last bit period completes.
REQ-013 underrun  output  1  sticky error flag.

Function
REQ-014 The FSM SHALL have states IDLE, LOADED and SEND.
REQ-015 load_sreg=1 in any state SHALL load sreg with pixel_data, clear bit_cnt and cyc_cnt, and enter LOADED; load_sreg has priority over all other events.
REQ-016 In LOADED or SEND with transmit_pixel=1, the next data_out SHALL be 1 when cyc_cnt < (sreg[23] ? T1H_CYCLES : T0H_CYCLES), else 0; state becomes SEND.
REQ-017 cyc_cnt SHALL count 0..CYCLES_PER_BIT-1 and wrap to 0; on wrap, sreg shifts left by one (MSB first) and bit_cnt increments.
REQ-018 When cyc_cnt wraps with bit_cnt = BITS_PER_PIXEL-1, the FSM SHALL return to IDLE and assert pixel_done for exactly the next cycle.
REQ-019 data_out SHALL lag the driving cycle by one clock, so the frame occupies BITS_PER_PIXEL x CYCLES_PER_BIT cycles (360 at defaults), offset by one.
REQ-020 In LOADED with transmit_pixel=0, the block SHALL hold state, counters and sreg, with data_out=0.
REQ-021 In SEND, transmit_pixel falling before the last bit completes SHALL abort to IDLE with data_out=0 next cycle and no pixel_done.
REQ-022 transmit_pixel=1 in IDLE with load_sreg=0 SHALL set underrun, keep data_out=0 and leave the state in IDLE.
REQ-023 In IDLE, data_out SHALL be 0 (line held low provides the WS2812 latch gap).
REQ-024 bit_cnt SHALL be 5 bits wide and cyc_cnt 4 bits wide; no other arithmetic is required.

Reset
REQ-025 rst=1 SHALL force IDLE, sreg=0, bit_cnt=0, cyc_cnt=0, data_out=0, busy=0, pixel_done=0 and underrun=0 at the next rising edge, overriding load_sreg, including mid-frame.

Configuration
REQ-026 With macro WS2812_TX_BRIGHTNESS_EN defined, the block SHALL add input brightness[2:0], and on load each 8-bit channel SHALL be logically right-shifted by brightness before entering sreg.
REQ-027 Without WS2812_TX_BRIGHTNESS_EN, the brightness port SHALL be absent and pixel_data SHALL load unmodified.

Verification
REQ-028 Load 24'h800000, then hold transmit_pixel high for 360 cycles -> first bit high for 9 cycles, low for 6; remaining 23 bits each high 4, low 11; pixel_done pulses once, at cycle 361.
REQ-029 Load 24'hFFFFFF, then 24'h000000, back to back with the controller pattern (load, transmit 360) -> 24 bits of 9/6, then 24 bits of 4/11; two pixel_done pulses.
REQ-030 Drop transmit_pixel at cycle 100 of the frame -> data_out is 0 from cycle 101, busy falls, and no pixel_done.
REQ-031 Assert transmit_pixel with no prior load after reset -> underrun=1 and data_out stays 0; underrun clears only on rst.
REQ-032 Assert rst at bit 10 of the frame -> all outputs 0 next cycle; a following load plus transmit sends a full correct frame.
REQ-033 With WS2812_TX_BRIGHTNESS_EN, brightness=1 and pixel_data 24'hFF8001 -> transmitted word is 24'h7F4000.
